// File: rtl/tx_scheduler.sv
// tx_scheduler: arbitrates the serial TX link between prefetcher and execute unit,
// shifts out header+payload and tags reads in order so RX payload can be routed back.
module tx_scheduler #(
    parameter int IO_BITS         = 2,
    parameter int PAYLOAD_CYCLES  = 8,
    parameter int CMD_BITS        = 4,
    parameter int MAX_OUTSTANDING = 2,
    localparam int CW = $clog2(PAYLOAD_CYCLES) + 1,
    localparam int BW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pf_valid,
    input  logic [CMD_BITS-1:0] pf_cmd,
    output logic                pf_started,
    input  logic [IO_BITS-1:0]  pf_data,
    input  logic                ex_valid,
    input  logic [CMD_BITS-1:0] ex_cmd,
    input  logic                ex_write,
    output logic                ex_started,
    input  logic [IO_BITS-1:0]  ex_data,
    output logic [IO_BITS-1:0]  tx_pins,
    output logic                tx_active,
    output logic                tx_data_next,
    output logic [CW-1:0]       tx_counter,
    output logic                tx_owner,
    output logic                tx_done,
    input  logic                rx_done,
    input  logic                rx_data_valid,
    output logic                rx_pf_valid,
    output logic                rx_ex_valid,
    output logic                rx_pf_done,
    output logic                rx_ex_done,
    output logic [BW-1:0]       busy_reads
);
    localparam int HDR = CMD_BITS / IO_BITS;
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, GAP} state_t;

    state_t                     state_q;
    logic [CMD_BITS-1:0]        cmd_q;
    logic                       owner_q, long_q, rr_last_q;
    logic [CW-1:0]              cnt_q;
    logic [MAX_OUTSTANDING-1:0] tag_q;
    logic [PW-1:0]              rd_q, wr_q, rd_d, wr_d;
    logic [BW-1:0]              busy_q, busy_d;
    logic                       room, pf_ok, ex_ok, grant_ex, accept, push, pop, head;
    logic                       in_hdr, in_pl, last_hdr, last_pl;

    always_comb begin
        room       = busy_q < BW'(MAX_OUTSTANDING);
        pf_ok      = pf_valid && room;
        ex_ok      = ex_valid && (ex_write || room);
        // rr_last_q set means the prefetcher was served last, so execute wins a tie
        grant_ex   = ex_ok && (!pf_ok || rr_last_q);
        accept     = (state_q == IDLE) && (pf_ok || ex_ok);
        pf_started = accept && !grant_ex;
        ex_started = accept && grant_ex;
        push       = pf_started || (ex_started && !ex_write);
        pop        = rx_done && (busy_q != '0);
        head       = tag_q[rd_q];
        rd_d       = pop ? ((rd_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_q + 1'b1) : rd_q;
        wr_d       = push ? ((wr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_q + 1'b1) : wr_q;
        busy_d     = busy_q + BW'(push) - BW'(pop);
        in_hdr     = state_q == HEADER;
        in_pl      = state_q == PAYLOAD;
        last_hdr   = cnt_q == CW'(HDR - 1);
        last_pl    = cnt_q == (long_q ? CW'(2 * PAYLOAD_CYCLES - 1) : CW'(PAYLOAD_CYCLES - 1));
        tx_pins    = in_hdr ? cmd_q[IO_BITS-1:0] : in_pl ? (owner_q ? ex_data : pf_data) : '0;
        tx_active  = in_hdr || in_pl;
        tx_data_next = in_pl;
        tx_counter = in_pl ? cnt_q : '0;
        tx_owner   = owner_q;
        tx_done    = in_pl && last_pl;
        rx_pf_valid = rx_data_valid && (busy_q != '0) && !head;
        rx_ex_valid = rx_data_valid && (busy_q != '0) && head;
        rx_pf_done  = pop && !head;
        rx_ex_done  = pop && head;
        busy_reads  = busy_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            owner_q   <= 1'b0;
            long_q    <= 1'b0;
            rr_last_q <= 1'b1;
            cnt_q     <= '0;
            tag_q     <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            busy_q    <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            busy_q <= busy_d;
            if (push) tag_q[wr_q] <= grant_ex;
            case (state_q)
                IDLE: if (accept) begin
                    state_q   <= HEADER;
                    cmd_q     <= grant_ex ? ex_cmd : pf_cmd;
                    owner_q   <= grant_ex;
                    long_q    <= grant_ex && ex_write;
                    rr_last_q <= !grant_ex;
                    cnt_q     <= '0;
                end
                HEADER: begin
                    cmd_q <= cmd_q >> IO_BITS;
                    cnt_q <= last_hdr ? '0 : cnt_q + 1'b1;
                    if (last_hdr) state_q <= PAYLOAD;
                end
                PAYLOAD: begin
                    cnt_q <= last_pl ? '0 : cnt_q + 1'b1;
                    if (last_pl) state_q <= GAP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_scheduler.sv
// tb_tx_scheduler: directed scenarios with literal expectations plus randomized traffic,
// every cycle compared against a transfer-timeline / tag-queue model.
module tb_tx_scheduler;
    localparam int H = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pf_valid = 1'b0, ex_valid = 1'b0, ex_write = 1'b0;
    logic [3:0] pf_cmd = '0, ex_cmd = '0;
    logic [1:0] pf_data = 2'd2, ex_data = 2'd3;
    logic       rx_done = 1'b0, rx_data_valid = 1'b0;
    logic       pf_started, ex_started, tx_active, tx_data_next, tx_owner, tx_done;
    logic       rx_pf_valid, rx_ex_valid, rx_pf_done, rx_ex_done;
    logic [1:0] tx_pins, busy_reads;
    logic [3:0] tx_counter;

    always #5 clk = ~clk;

    tx_scheduler dut (
        .clk(clk), .reset(reset),
        .pf_valid(pf_valid), .pf_cmd(pf_cmd), .pf_started(pf_started), .pf_data(pf_data),
        .ex_valid(ex_valid), .ex_cmd(ex_cmd), .ex_write(ex_write), .ex_started(ex_started),
        .ex_data(ex_data), .tx_pins(tx_pins), .tx_active(tx_active), .tx_data_next(tx_data_next),
        .tx_counter(tx_counter), .tx_owner(tx_owner), .tx_done(tx_done),
        .rx_done(rx_done), .rx_data_valid(rx_data_valid),
        .rx_pf_valid(rx_pf_valid), .rx_ex_valid(rx_ex_valid),
        .rx_pf_done(rx_pf_done), .rx_ex_done(rx_ex_done), .busy_reads(busy_reads)
    );

    int tests = 0, fails = 0;

    // model: m_pos is the cycle index inside the current transfer (-1 when idle);
    // header occupies 0..H-1, payload H..H+n-1, turnaround gap at H+n
    bit         m_on = 1'b0;
    int         m_pos = -1;
    bit         m_owner;
    logic [3:0] m_cmd;
    int         m_n;
    bit         m_pf_last = 1'b1;
    bit         tags[$];
    bit         e_pf_st, e_ex_st;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        int         busy = tags.size();
        bit         idle = m_pos < 0;
        bit         pf_ok = pf_valid && busy < 2;
        bit         ex_ok = ex_valid && (ex_write || busy < 2);
        bit         win_ex = (pf_ok && ex_ok) ? m_pf_last : ex_ok;
        bit         acc = idle && (pf_ok || ex_ok);
        int         k = m_pos - H;
        bit         hdr = !idle && m_pos < H;
        bit         pl = !idle && k >= 0 && k < m_n;
        bit         head = (busy > 0) ? tags[0] : 1'b0;
        logic [1:0] pins = hdr ? 2'(m_cmd >> (2 * m_pos)) : pl ? (m_owner ? ex_data : pf_data) : 2'd0;
        e_pf_st = acc && !win_ex;
        e_ex_st = acc && win_ex;
        if (m_on) begin
            chk("pf_started", pf_started, e_pf_st);
            chk("ex_started", ex_started, e_ex_st);
            chk("tx_pins", tx_pins, pins);
            chk("tx_active", tx_active, hdr || pl);
            chk("tx_data_next", tx_data_next, pl);
            chk("tx_counter", tx_counter, pl ? k : 0);
            chk("tx_done", tx_done, pl && k == m_n - 1);
            if (hdr || pl) chk("tx_owner", tx_owner, m_owner);
            chk("busy_reads", busy_reads, busy);
            chk("rx_pf_valid", rx_pf_valid, rx_data_valid && busy > 0 && !head);
            chk("rx_ex_valid", rx_ex_valid, rx_data_valid && busy > 0 && head);
            chk("rx_pf_done", rx_pf_done, rx_done && busy > 0 && !head);
            chk("rx_ex_done", rx_ex_done, rx_done && busy > 0 && head);
        end
        if (reset) begin
            m_pos = -1;
            tags.delete();
            m_pf_last = 1'b1;
        end else begin
            if (rx_done && busy > 0) void'(tags.pop_front());
            if (acc) begin
                m_pos = 0;
                m_owner = win_ex;
                m_cmd = win_ex ? ex_cmd : pf_cmd;
                m_n = (win_ex && ex_write) ? 16 : 8;
                m_pf_last = !win_ex;
                if (!(win_ex && ex_write)) tags.push_back(win_ex);
            end else if (!idle) begin
                m_pos = (m_pos >= H + m_n) ? -1 : m_pos + 1;
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            adv();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pf_valid = 0; ex_valid = 0; ex_write = 0; rx_done = 0; rx_data_valid = 0;
        pf_data = 2'd2; ex_data = 2'd3;
        sample();
        m_on = 1'b1;
        adv();
        reset = 1'b0;
    endtask

    int  n, cnt, mx;
    bit  got, seen;

    initial begin
        // reset state
        do_reset();
        sample();
        chk("rst_active", tx_active, 0);
        chk("rst_pins", tx_pins, 0);
        chk("rst_counter", tx_counter, 0);
        chk("rst_busy", busy_reads, 0);
        adv();

        // single prefetch read, cmd 5 -> header groups 1,1 then 8 payload cycles
        pf_valid = 1; pf_cmd = 4'h5;
        sample();
        chk("t1_started", pf_started, 1);
        adv();
        pf_valid = 0;
        for (int i = 1; i <= 11; i++) begin
            sample();
            chk("t1_active", tx_active, i <= 10);
            chk("t1_done", tx_done, i == 10);
            if (i <= 2) chk("t1_hdr_pins", tx_pins, 1);
            if (i >= 3 && i <= 10) chk("t1_counter", tx_counter, i - 3);
            if (i == 11) chk("t1_busy", busy_reads, 1);
            adv();
        end

        // tie from reset: execute first, then prefetch
        do_reset();
        pf_valid = 1; pf_cmd = 4'h3; ex_valid = 1; ex_cmd = 4'hA; ex_write = 0;
        sample();
        chk("t2_ex_first", ex_started, 1);
        chk("t2_pf_wait", pf_started, 0);
        adv();
        ex_valid = 0;
        sample();
        chk("t2_owner_ex", tx_owner, 1);
        adv();
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            sample();
            got = pf_started;
            adv();
        end
        pf_valid = 0;
        chk("t2_pf_started", got, 1);
        sample();
        chk("t2_owner_pf", tx_owner, 0);
        chk("t2_busy", busy_reads, 2);
        adv();

        // execute write: 16 payload cycles, no tag
        do_reset();
        ex_valid = 1; ex_write = 1; ex_cmd = 4'hC;
        step(1);
        ex_valid = 0; ex_write = 0;
        cnt = 0; mx = 0;
        for (int i = 0; i < 25; i++) begin
            sample();
            if (tx_data_next) cnt++;
            if (int'(tx_counter) > mx) mx = int'(tx_counter);
            adv();
        end
        chk("t3_payload_len", cnt, 16);
        chk("t3_max_counter", mx, 15);
        chk("t3_busy", busy_reads, 0);

        // two reads outstanding block a third until rx_done
        do_reset();
        pf_valid = 1; pf_cmd = 4'h5;
        n = 0;
        for (int i = 0; i < 60 && n < 2; i++) begin
            sample();
            n += int'(pf_started);
            adv();
        end
        chk("t4_two_pf", n, 2);
        pf_valid = 0; ex_valid = 1; ex_write = 0; ex_cmd = 4'h6;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            sample();
            seen |= ex_started | pf_started;
            adv();
        end
        chk("t4_blocked", seen, 0);
        chk("t4_busy_full", busy_reads, 2);
        rx_done = 1;
        sample();
        chk("t4_rx_pf_done", rx_pf_done, 1);
        chk("t4_no_start_yet", ex_started, 0);
        adv();
        rx_done = 0;
        sample();
        chk("t4_ex_started", ex_started, 1);
        adv();
        ex_valid = 0;

        // push and pop in the same cycle keep the count and advance the head
        do_reset();
        pf_valid = 1; pf_cmd = 4'h1;
        step(1);
        pf_valid = 0;
        step(11);
        ex_valid = 1; ex_write = 0; ex_cmd = 4'h2; rx_done = 1;
        sample();
        chk("t5_ex_started", ex_started, 1);
        chk("t5_rx_pf_done", rx_pf_done, 1);
        adv();
        ex_valid = 0; rx_done = 0; rx_data_valid = 1;
        sample();
        chk("t5_busy", busy_reads, 1);
        chk("t5_rx_ex_valid", rx_ex_valid, 1);
        chk("t5_rx_pf_valid", rx_pf_valid, 0);
        adv();
        rx_data_valid = 0;

        // reset during payload cycle 3 aborts immediately
        do_reset();
        pf_valid = 1; pf_cmd = 4'h9;
        step(1);
        pf_valid = 0;
        step(5);
        reset = 1;
        sample();
        chk("t6_counter", tx_counter, 3);
        adv();
        reset = 0;
        sample();
        chk("t6_active", tx_active, 0);
        chk("t6_pins", tx_pins, 0);
        chk("t6_busy", busy_reads, 0);
        adv();
        pf_valid = 1;
        sample();
        chk("t6_restart", pf_started, 1);
        adv();
        pf_valid = 0;
        sample();
        chk("t6_hdr_active", tx_active, 1);
        chk("t6_hdr_pins", tx_pins, 1);
        adv();

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            sample();
            adv();
            if (e_pf_st || !pf_valid) begin
                pf_valid = ($urandom_range(0, 2) == 0);
                pf_cmd = 4'($urandom);
            end else if (m_pos < 0 && $urandom_range(0, 7) == 0) pf_valid = 0;
            if (e_ex_st || !ex_valid) begin
                ex_valid = ($urandom_range(0, 3) == 0);
                ex_write = 1'($urandom);
                ex_cmd = 4'($urandom);
            end else if (m_pos < 0 && $urandom_range(0, 7) == 0) ex_valid = 0;
            pf_data = 2'($urandom);
            ex_data = 2'($urandom);
            rx_done = ($urandom_range(0, 5) == 0);
            rx_data_valid = 1'($urandom);
            reset = ($urandom_range(0, 299) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
